// File: rtl/eq_pkg.sv
// Shared definitions for the equalizer band controller.
// Default sizes, FSM state encoding and gain type.
package eq_pkg;

    localparam int DEF_NUM_BANDS = 8;
    localparam int DEF_GAIN_W    = 3;
    localparam int DEF_IDX_W     = 3;

    typedef enum logic {
        IDLE = 1'b0,
        RAMP = 1'b1
    } state_t;

    typedef logic [DEF_GAIN_W-1:0] gain_t;

endpackage

// File: rtl/eq_gain_ramp.sv
// Per-band gain ramp: walks the live gain one LSB per step
// toward the effective target and sequences the band enable.
module eq_gain_ramp
    import eq_pkg::*;
#(
    parameter int GAIN_W = DEF_GAIN_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              step,
    input  logic              tgt_ena,
    input  logic [GAIN_W-1:0] tgt_gain,
    output logic [GAIN_W-1:0] gain,
    output logic              ena,
    output logic              settled
);

    logic [GAIN_W-1:0] cur_q;
    logic [GAIN_W-1:0] cur_d;
    logic              ena_q;
    logic              ena_d;
    logic [GAIN_W-1:0] eff;

    assign eff = tgt_ena ? tgt_gain : '0;

    // Step toward eff and hold enable until the gain reaches zero.
    always_comb begin
        cur_d = cur_q;
        ena_d = ena_q;
        if (step) begin
            if (cur_q < eff) begin
                cur_d = cur_q + GAIN_W'(1);
            end else if (cur_q > eff) begin
                cur_d = cur_q - GAIN_W'(1);
            end
        end
        if (tgt_ena) begin
            ena_d = 1'b1;
        end else if (cur_q == '0) begin
            ena_d = 1'b0;
        end
    end

    // Live gain and enable registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur_q <= '0;
            ena_q <= 1'b0;
        end else begin
            cur_q <= cur_d;
            ena_q <= ena_d;
        end
    end

    assign gain    = cur_q;
    assign ena     = ena_q;
    assign settled = (cur_q == eff) && (ena_q == tgt_ena);

endmodule

// File: rtl/eq_band_ctrl.sv
// Equalizer band configuration sequencer: staged writes,
// atomic commit to all bands, then zipper-free gain ramps.
module eq_band_ctrl
    import eq_pkg::*;
#(
    parameter int NUM_BANDS = DEF_NUM_BANDS,
    parameter int GAIN_W    = DEF_GAIN_W,
    parameter int IDX_W     = DEF_IDX_W
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        cfg_valid,
    output logic                        cfg_ready,
    input  logic [IDX_W-1:0]            cfg_band,
    input  logic                        cfg_ena,
    input  logic [GAIN_W-1:0]           cfg_gain,
    output logic                        cfg_err,
    input  logic                        commit,
    input  logic                        sample_tick,
    output logic [NUM_BANDS-1:0]        ena_out,
    output logic [NUM_BANDS*GAIN_W-1:0] gain_out,
    output logic                        busy
);

    localparam int GW = NUM_BANDS * GAIN_W;

    state_t          state_q;
    state_t          state_d;
    logic            pend_q;
    logic            pend_d;
    logic            err_q;
    logic            err_d;
    logic            load;
    logic            step;
    logic            in_range;
    logic            wr_ok;

    logic [NUM_BANDS-1:0] stg_ena_q;
    logic [NUM_BANDS-1:0] stg_ena_d;
    logic [GW-1:0]        stg_gain_q;
    logic [GW-1:0]        stg_gain_d;
    logic [NUM_BANDS-1:0] tgt_ena_q;
    logic [NUM_BANDS-1:0] tgt_ena_d;
    logic [GW-1:0]        tgt_gain_q;
    logic [GW-1:0]        tgt_gain_d;
    logic [NUM_BANDS-1:0] settled;

    assign cfg_ready = 1'b1;
    assign in_range  = int'(cfg_band) < NUM_BANDS;
    assign wr_ok     = cfg_valid && in_range;
    assign step      = sample_tick && (state_q == RAMP);
    assign busy      = (state_q != IDLE) || pend_q;
    assign cfg_err   = err_q;

    // Staging writes; out-of-range bands are dropped and flagged.
    always_comb begin
        stg_ena_d  = stg_ena_q;
        stg_gain_d = stg_gain_q;
        err_d      = cfg_valid && !in_range;
        for (int b = 0; b < NUM_BANDS; b++) begin
            if (wr_ok && cfg_band == IDX_W'(b)) begin
                stg_ena_d[b] = cfg_ena;
                stg_gain_d[b*GAIN_W +: GAIN_W] = cfg_gain;
            end
        end
    end

    // Commit sequencing: load targets in IDLE, defer commits seen in RAMP.
    always_comb begin
        state_d = state_q;
        pend_d  = pend_q;
        load    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (commit || pend_q) begin
                    load    = 1'b1;
                    pend_d  = 1'b0;
                    state_d = RAMP;
                end
            end
            RAMP: begin
                if (commit) begin
                    pend_d = 1'b1;
                end
                if (&settled) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        tgt_ena_d  = load ? stg_ena_q  : tgt_ena_q;
        tgt_gain_d = load ? stg_gain_q : tgt_gain_q;
    end

    // Control, staging and target registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            pend_q     <= 1'b0;
            err_q      <= 1'b0;
            stg_ena_q  <= '0;
            stg_gain_q <= '0;
            tgt_ena_q  <= '0;
            tgt_gain_q <= '0;
        end else begin
            state_q    <= state_d;
            pend_q     <= pend_d;
            err_q      <= err_d;
            stg_ena_q  <= stg_ena_d;
            stg_gain_q <= stg_gain_d;
            tgt_ena_q  <= tgt_ena_d;
            tgt_gain_q <= tgt_gain_d;
        end
    end

    for (genvar b = 0; b < NUM_BANDS; b++) begin : g_band
        eq_gain_ramp #(
            .GAIN_W (GAIN_W)
        ) u_ramp (
            .clk      (clk),
            .rst_n    (rst_n),
            .step     (step),
            .tgt_ena  (tgt_ena_q[b]),
            .tgt_gain (tgt_gain_q[b*GAIN_W +: GAIN_W]),
            .gain     (gain_out[b*GAIN_W +: GAIN_W]),
            .ena      (ena_out[b]),
            .settled  (settled[b])
        );
    end

endmodule
